alsu_pipe: RTL and testbench

- Parametrised, pipelined successor of the team's 3-bit ALSU.
- Accepts operand/opcode transactions over a valid/ready handshake and computes logic, arithmetic, shift and rotate results in a 2-stage pipeline with full backpressure.
- Flags illegal requests with an error bit, a blinking LED bank and a saturating error counter.
- Sits between the stimulus/control front end and the LED/result sink on the board.

---
 rtl/alsu_pkg.sv | 32 +++
 rtl/alsu_core.sv | 73 +++++++
 rtl/alsu_pipe.sv | 126 ++++++++++++
 tb/tb_alsu_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared opcode, priority and stage-1 control types for the pipelined ALSU
package alsu_pkg;

  typedef enum logic [2:0] {
    OR_AND = 3'd0,
    XOR    = 3'd1,
    ADD    = 3'd2,
    MULT   = 3'd3,
    SHIFT  = 3'd4,
    ROTATE = 3'd5,
    INV6   = 3'd6,
    INV7   = 3'd7
  } opcode_e;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } priority_e;

  // Width-independent part of a stage-1 transaction; operands are added by the user module.
  typedef struct packed {
    opcode_e opcode;
    logic    cin;
    logic    serial_in;
    logic    red_op_a;
    logic    red_op_b;
    logic    bypass_a;
    logic    bypass_b;
    logic    direction;
  } s1_ctrl_t;

endpackage

// File: rtl/alsu_core.sv
// rtl/alsu_core.sv - combinational evaluation of one stage-1 transaction against the shift register
module alsu_core import alsu_pkg::*; #(
  parameter int        WIDTH      = 3,
  parameter int        OUT_W      = 2 * WIDTH,
  parameter int        FULL_ADDER = 1,
  parameter priority_e PRIO       = PRIO_A
) (
  input  s1_ctrl_t                 ctrl,
  input  logic signed [WIDTH-1:0]  a,
  input  logic signed [WIDTH-1:0]  b,
  input  logic        [OUT_W-1:0]  sr,
  output logic signed [OUT_W-1:0]  out,
  output logic                     err,
  output logic        [OUT_W-1:0]  sr_next
);

  logic signed [OUT_W-1:0] ext_a;
  logic signed [OUT_W-1:0] ext_b;
  logic        [OUT_W-1:0] carry;
  logic        [OUT_W-1:0] sr_shift;
  logic        [OUT_W-1:0] sr_rot;
  logic        [WIDTH-1:0] red_operand;
  logic                    sel_bypass_a;
  logic                    sel_red_a;
  logic                    red_req;
  logic                    illegal;

  assign ext_a = {{(OUT_W-WIDTH){a[WIDTH-1]}}, a};
  assign ext_b = {{(OUT_W-WIDTH){b[WIDTH-1]}}, b};
  assign carry = (FULL_ADDER != 0) ? {{(OUT_W-1){1'b0}}, ctrl.cin} : '0;

  assign sel_bypass_a = ctrl.bypass_a && (!ctrl.bypass_b || PRIO == PRIO_A);
  assign sel_red_a    = ctrl.red_op_a && (!ctrl.red_op_b || PRIO == PRIO_A);
  assign red_req      = ctrl.red_op_a || ctrl.red_op_b;
  assign red_operand  = sel_red_a ? a : b;

  // Reductions are only meaningful for AND/XOR; asking for one elsewhere is a malformed request.
  assign illegal = (ctrl.opcode inside {INV6, INV7}) ||
                   (red_req && !(ctrl.opcode inside {OR_AND, XOR}));

  assign sr_shift = ctrl.direction ? {sr[OUT_W-2:0], ctrl.serial_in}
                                   : {ctrl.serial_in, sr[OUT_W-1:1]};
  assign sr_rot   = ctrl.direction ? {sr[OUT_W-2:0], sr[OUT_W-1]}
                                   : {sr[0], sr[OUT_W-1:1]};

  always_comb begin
    out     = '0;
    err     = 1'b0;
    sr_next = sr;
    if (ctrl.bypass_a || ctrl.bypass_b) begin
      out = sel_bypass_a ? ext_a : ext_b;
    end else if (illegal) begin
      err = 1'b1;
    end else begin
      case (ctrl.opcode)
        OR_AND: out = red_req ? {{(OUT_W-1){1'b0}}, &red_operand} : (ext_a & ext_b);
        XOR:    out = red_req ? {{(OUT_W-1){1'b0}}, ^red_operand} : (ext_a ^ ext_b);
        ADD:    out = ext_a + ext_b + carry;
        MULT:   out = ext_a * ext_b;
        SHIFT: begin
          sr_next = sr_shift;
          out     = sr_shift;
        end
        ROTATE: begin
          sr_next = sr_rot;
          out     = sr_rot;
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// rtl/alsu_pipe.sv - two-stage valid/ready ALSU with error LEDs and saturating error counter
module alsu_pipe import alsu_pkg::*; #(
  parameter int WIDTH          = 3,
  parameter int OUT_W          = 2 * WIDTH,
  parameter int LED_W          = 16,
  parameter int FULL_ADDER     = 1,
  parameter     INPUT_PRIORITY = "A",
  parameter int ERR_CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              opcode,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    cin,
  input  logic                    serial_in,
  input  logic                    red_op_A,
  input  logic                    red_op_B,
  input  logic                    bypass_A,
  input  logic                    bypass_B,
  input  logic                    direction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out,
  output logic [OUT_W-1:0]        out_shift_reg,
  output logic                    err,
  output logic [LED_W-1:0]        leds,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam priority_e PRIO = (INPUT_PRIORITY == "B") ? PRIO_B : PRIO_A;

  typedef struct packed {
    s1_ctrl_t                ctrl;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
  } s1_t;

  s1_t                     s1;
  logic                    s1_valid;
  logic [OUT_W-1:0]        sr;
  logic signed [OUT_W-1:0] core_out;
  logic                    core_err;
  logic [OUT_W-1:0]        core_sr_next;
  logic                    s2_load;
  logic                    s2_take;
  logic                    accept;

  assign s2_load       = !out_valid || out_ready;
  assign s2_take       = s2_load && s1_valid;
  assign in_ready      = !s1_valid || s2_load;
  assign accept        = in_valid && in_ready;
  assign out_shift_reg = sr;

  alsu_core #(
    .WIDTH      (WIDTH),
    .OUT_W      (OUT_W),
    .FULL_ADDER (FULL_ADDER),
    .PRIO       (PRIO)
  ) u_core (
    .ctrl    (s1.ctrl),
    .a       (s1.a),
    .b       (s1.b),
    .sr      (sr),
    .out     (core_out),
    .err     (core_err),
    .sr_next (core_sr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (accept) begin
      s1_valid              <= 1'b1;
      s1.ctrl.opcode        <= opcode_e'(opcode);
      s1.ctrl.cin           <= cin;
      s1.ctrl.serial_in     <= serial_in;
      s1.ctrl.red_op_a      <= red_op_A;
      s1.ctrl.red_op_b      <= red_op_B;
      s1.ctrl.bypass_a      <= bypass_A;
      s1.ctrl.bypass_b      <= bypass_B;
      s1.ctrl.direction     <= direction;
      s1.a                  <= A;
      s1.b                  <= B;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // out/err keep the last result after it is consumed, so the LED blink follows the last error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
      sr        <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= core_out;
        err <= core_err;
        sr  <= core_sr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds    <= '0;
      err_cnt <= '0;
    end else begin
      if (s2_take) begin
        leds <= core_err ? '1 : '0;
      end else if (err) begin
        leds <= ~leds;
      end
      if (s2_take && core_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alsu_pipe.sv
// tb/tb_alsu_pipe.sv - randomized and directed checks of alsu_pipe against a transaction-level model
module tb_alsu_pipe;

  localparam int W  = 3;
  localparam int OW = 6;
  localparam int LW = 16;
  localparam int CW = 8;
  localparam bit PRIO_IS_A = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [2:0]           opcode = '0;
  logic signed [W-1:0]  A = '0;
  logic signed [W-1:0]  B = '0;
  logic                 cin = 1'b0;
  logic                 serial_in = 1'b0;
  logic                 red_op_A = 1'b0;
  logic                 red_op_B = 1'b0;
  logic                 bypass_A = 1'b0;
  logic                 bypass_B = 1'b0;
  logic                 direction = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [OW-1:0] out;
  logic [OW-1:0]        out_shift_reg;
  logic                 err;
  logic [LW-1:0]        leds;
  logic [CW-1:0]        err_cnt;

  alsu_pipe #(
    .WIDTH(W), .OUT_W(OW), .LED_W(LW), .FULL_ADDER(1), .INPUT_PRIORITY("A"), .ERR_CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .A(A), .B(B), .cin(cin), .serial_in(serial_in), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_shift_reg(out_shift_reg), .err(err), .leds(leds),
    .err_cnt(err_cnt)
  );

  typedef struct {
    logic [2:0]          op;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic cin, si, dir, ra, rb, ba, bb;
  } txn_t;

  typedef struct {
    logic [OW-1:0] out;
    logic          err;
    logic [OW-1:0] sr;
  } item_t;

  int total = 0;
  int bad = 0;

  item_t         pend_q[$];
  item_t         pres;
  bit            pres_valid = 1'b0;
  logic [LW-1:0] m_leds = '0;
  int            m_cnt = 0;
  int            m_sr = 0;
  logic [OW-1:0] m_disp_sr = '0;
  logic [OW:0]   got_q[$];
  bit            rand_mode = 1'b0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endfunction

  // Reference: the operation rules evaluated on plain integers in acceptance order.
  function automatic item_t predict(input txn_t t);
    item_t it;
    int a, b, r, u, mask, top;
    mask = (1 << OW) - 1;
    top  = 1 << (OW - 1);
    a = t.a;
    b = t.b;
    r = 0;
    it.err = 1'b0;
    if (t.ba || t.bb) begin
      r = (t.ba && (!t.bb || PRIO_IS_A)) ? a : b;
    end else if (t.op >= 6 || ((t.ra || t.rb) && t.op >= 2)) begin
      it.err = 1'b1;
    end else if (t.ra || t.rb) begin
      u = ((t.ra && (!t.rb || PRIO_IS_A)) ? a : b) & ((1 << W) - 1);
      r = (t.op == 0) ? int'(u == (1 << W) - 1) : ($countones(u) % 2);
    end else begin
      case (t.op)
        3'd0: r = a & b;
        3'd1: r = a ^ b;
        3'd2: r = a + b + int'(t.cin);
        3'd3: r = a * b;
        3'd4: begin
          m_sr = t.dir ? ((m_sr * 2 + int'(t.si)) & mask) : (m_sr / 2 + int'(t.si) * top);
          r = m_sr;
        end
        3'd5: begin
          m_sr = t.dir ? (((m_sr * 2) & mask) + m_sr / top) : (m_sr / 2 + (m_sr % 2) * top);
          r = m_sr;
        end
        default: r = 0;
      endcase
    end
    it.out = r[OW-1:0];
    it.sr  = m_sr[OW-1:0];
    return it;
  endfunction

  always @(negedge clk) begin
    bit exp_ready, load, xfer;
    txn_t t;
    if (!reset) begin
      pend_q.delete();
      pres_valid = 1'b0;
      pres = '{default: 0};
      m_leds = '0;
      m_cnt = 0;
      m_sr = 0;
      m_disp_sr = '0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out", $unsigned(out), 0);
      check("rst_err", err, 0);
      check("rst_leds", leds, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_sr", out_shift_reg, 0);
    end else begin
      exp_ready = (pend_q.size() == 0) || !pres_valid || out_ready;
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, pres_valid);
      if (pres_valid) begin
        check("out", $unsigned(out), pres.out);
        check("err", err, pres.err);
      end
      check("leds", leds, m_leds);
      check("err_cnt", err_cnt, m_cnt);
      check("shift_reg", out_shift_reg, m_disp_sr);
      xfer = pres_valid && out_ready;
      load = (!pres_valid || out_ready) && (pend_q.size() > 0);
      if (xfer) got_q.push_back({pres.err, pres.out});
      if (load) begin
        pres = pend_q.pop_front();
        pres_valid = 1'b1;
        m_disp_sr = pres.sr;
        if (pres.err) begin
          m_leds = '1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_leds = '0;
        end
      end else begin
        if (xfer) pres_valid = 1'b0;
        if (pres.err) m_leds = ~m_leds;
      end
      if (in_valid && exp_ready) begin
        t.op = opcode; t.a = A; t.b = B; t.cin = cin; t.si = serial_in; t.dir = direction;
        t.ra = red_op_A; t.rb = red_op_B; t.ba = bypass_A; t.bb = bypass_B;
        pend_q.push_back(predict(t));
      end
    end
  end

  function automatic txn_t mk(input int op, input int a, input int b, input bit c, input bit si,
                              input bit dir, input bit ra, input bit rb, input bit ba, input bit bb);
    txn_t t;
    t.op = op[2:0]; t.a = a[W-1:0]; t.b = b[W-1:0]; t.cin = c; t.si = si; t.dir = dir;
    t.ra = ra; t.rb = rb; t.ba = ba; t.bb = bb;
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input txn_t t);
    opcode = t.op; A = t.a; B = t.b; cin = t.cin; serial_in = t.si; direction = t.dir;
    red_op_A = t.ra; red_op_B = t.rb; bypass_A = t.ba; bypass_B = t.bb;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit r;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      cyc();
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!r && n < 500);
    if (!r) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send(input txn_t t);
    apply(t);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend_q.size() != 0 || pres_valid) && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int base;
    txn_t t;
    reset = 1'b0;
    #2;
    check("por_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    send(mk(2, 3, -2, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk); check("add_valid_c1", out_valid, 0);
    @(negedge clk);
    check("add_valid_c2", out_valid, 1);
    check("add_out", $unsigned(out), 6'd2);
    check("add_err", err, 0);
    cyc();

    out_ready = 1'b0;
    base = got_q.size();
    send(mk(3, 3, -4, 0, 0, 0, 0, 0, 0, 0));
    send(mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, -1, 2, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mult_stall_in_ready", in_ready, 0);
      check("mult_hold_out", $unsigned(out), 6'b110100);
      cyc();
    end
    out_ready = 1'b1;
    wait_accept();
    drain();
    check("stall_count", got_q.size(), base + 3);
    check("stall_r0", got_q[base], {1'b0, 6'b110100});
    check("stall_r1", got_q[base+1], {1'b0, 6'b000010});
    check("stall_r2", got_q[base+2], {1'b0, 6'b111101});

    base = got_q.size();
    for (int i = 0; i < 3; i++) send(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    send(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();
    check("shl1", got_q[base], {1'b0, 6'b000001});
    check("shl2", got_q[base+1], {1'b0, 6'b000011});
    check("shl3", got_q[base+2], {1'b0, 6'b000111});
    check("rotr", got_q[base+3], {1'b0, 6'b100011});
    check("rotr_sr", out_shift_reg, 6'b100011);

    base = got_q.size();
    send(mk(6, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); cyc();
    @(negedge clk);
    check("ill_err", err, 1);
    check("ill_out", $unsigned(out), 0);
    check("ill_leds0", leds, 16'hFFFF);
    check("ill_cnt", err_cnt, 1);
    cyc();
    @(negedge clk); check("ill_leds1", leds, 16'h0000); cyc();
    @(negedge clk); check("ill_leds2", leds, 16'hFFFF); cyc();
    send(mk(1, 5, 3, 0, 0, 0, 0, 0, 0, 0));
    drain();
    check("ill_res", got_q[base], {1'b1, 6'b000000});
    check("xor_res", got_q[base+1], {1'b0, 6'b111110});
    @(negedge clk); check("xor_leds", leds, 16'h0000); cyc();

    base = got_q.size();
    send(mk(3, -1, 2, 0, 0, 0, 0, 0, 1, 1));
    send(mk(2, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    send(mk(0, -1, 0, 0, 0, 0, 0, 1, 0, 0));
    drain();
    check("bypass_prio_a", got_q[base], {1'b0, 6'b111111});
    check("red_on_add", got_q[base+1], {1'b1, 6'b000000});
    check("red_and_b", got_q[base+2], {1'b0, 6'b000000});

    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      t.op = 3'($urandom_range(0, 7));
      t.a = W'($urandom); t.b = W'($urandom);
      t.cin = 1'($urandom); t.si = 1'($urandom); t.dir = 1'($urandom);
      t.ra = ($urandom_range(0, 4) == 0); t.rb = ($urandom_range(0, 4) == 0);
      t.ba = ($urandom_range(0, 7) == 0); t.bb = ($urandom_range(0, 7) == 0);
      send(t);
      repeat ($urandom_range(0, 1)) begin
        cyc();
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    send(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    send(mk(3, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out", $unsigned(out), 0);
    check("async_leds", leds, 0);
    check("async_err_cnt", err_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 300; i++) send(mk(7, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    drain();
    @(negedge clk);
    check("err_cnt_sat", err_cnt, 255);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
